// File: rtl/crc_pkg.sv
// Shared constants and FSM encoding for the CRC-4 frame checker.
// Generator g(x) = x^4 + x + 1.
package crc_pkg;

  localparam int unsigned CODE_W = 15;
  localparam int unsigned DATA_W = 11;
  localparam int unsigned CRC_W  = 4;

  localparam logic [CRC_W-1:0] POLY   = 4'b0011;
  localparam logic [CRC_W-1:0] NO_POS = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    LOCATE,
    DONE
  } state_e;

endpackage

// File: rtl/crc_frame_checker_if.sv
// Valid/ready bundle between the CRC encoder link and the checker.
// slave = checker side, master = producer/consumer side.
interface crc_frame_checker_if;
  import crc_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CRC_W-1:0]  out_syndrome;
  logic              out_err;
  logic              out_corrected;
  logic [CRC_W-1:0]  out_err_pos;

  modport slave (
    input  in_valid,
    input  in_code,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_syndrome,
    output out_err,
    output out_corrected,
    output out_err_pos
  );

  modport master (
    output in_valid,
    output in_code,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_syndrome,
    input  out_err,
    input  out_corrected,
    input  out_err_pos
  );

endinterface

// File: rtl/crc_lfsr4.sv
// One serial division step by g(x): next = {C, B, A^D, bit^D}.
// With bit=0 this multiplies the state by x mod g.
module crc_lfsr4
  import crc_pkg::*;
(
  input  logic [CRC_W-1:0] state_i,
  input  logic             bit_i,
  output logic [CRC_W-1:0] next_o
);

  assign next_o = {state_i[CRC_W-2:0], bit_i}
                ^ (state_i[CRC_W-1] ? POLY : '0);

endmodule

// File: rtl/crc_frame_checker.sv
// Bit-serial CRC-4 syndrome check; single-bit correction by
// sequential search when CRC_CORRECT_EN is defined.
module crc_frame_checker
  import crc_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  crc_frame_checker_if.slave bus
);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CRC_W-1:0]  syn_q, syn_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] odat_q, odat_d;
  logic [CRC_W-1:0]  osyn_q, osyn_d;
  logic              oerr_q, oerr_d;
  logic              ocor_q, ocor_d;
  logic [CRC_W-1:0]  opos_q, opos_d;
  logic [CRC_W-1:0]  lfsr_s, lfsr_n;
  logic              lfsr_b;
  logic [CODE_W-1:0] rot;
`ifdef CRC_CORRECT_EN
  logic [CRC_W-1:0]  cand_q, cand_d;
  logic [CODE_W-1:0] flip;
`endif

  crc_lfsr4 u_lfsr (
    .state_i (lfsr_s),
    .bit_i   (lfsr_b),
    .next_o  (lfsr_n)
  );

  // Rotating the codeword feeds MSB first and restores it after 15 steps.
  assign rot = {code_q[CODE_W-2:0], code_q[CODE_W-1]};
`ifdef CRC_CORRECT_EN
  assign flip = code_q ^ (CODE_W'(1) << cnt_q);
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    syn_d   = syn_q;
    cnt_d   = cnt_q;
    odat_d  = odat_q;
    osyn_d  = osyn_q;
    oerr_d  = oerr_q;
    ocor_d  = ocor_q;
    opos_d  = opos_q;
    lfsr_s  = syn_q;
    lfsr_b  = code_q[CODE_W-1];
`ifdef CRC_CORRECT_EN
    cand_d  = cand_q;
    if (state_q == LOCATE) begin
      lfsr_s = cand_q;
      lfsr_b = 1'b0;
    end
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          code_d  = bus.in_code;
          syn_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        code_d = rot;
        syn_d  = lfsr_n;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'(CODE_W - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
          odat_d  = rot[CODE_W-1:CRC_W];
          osyn_d  = lfsr_n;
          oerr_d  = |lfsr_n;
          ocor_d  = 1'b0;
          opos_d  = NO_POS;
`ifdef CRC_CORRECT_EN
          if (|lfsr_n) begin
            state_d = LOCATE;
            cand_d  = 4'b0001;
            odat_d  = odat_q;
            osyn_d  = osyn_q;
            oerr_d  = oerr_q;
            ocor_d  = ocor_q;
            opos_d  = opos_q;
          end
`endif
        end
      end
`ifdef CRC_CORRECT_EN
      LOCATE: begin
        if (cand_q == syn_q) begin
          code_d  = flip;
          state_d = DONE;
          odat_d  = flip[CODE_W-1:CRC_W];
          osyn_d  = syn_q;
          oerr_d  = 1'b1;
          ocor_d  = 1'b1;
          opos_d  = cnt_q;
        end else if (cnt_q == 4'(CODE_W - 1)) begin
          state_d = DONE;
          odat_d  = code_q[CODE_W-1:CRC_W];
          osyn_d  = syn_q;
          oerr_d  = |syn_q;
          ocor_d  = 1'b0;
          opos_d  = NO_POS;
        end else begin
          cand_d = lfsr_n;
          cnt_d  = cnt_q + 4'd1;
        end
      end
`endif
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      syn_q   <= '0;
      cnt_q   <= '0;
      odat_q  <= '0;
      osyn_q  <= '0;
      oerr_q  <= 1'b0;
      ocor_q  <= 1'b0;
      opos_q  <= NO_POS;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      syn_q   <= syn_d;
      cnt_q   <= cnt_d;
      odat_q  <= odat_d;
      osyn_q  <= osyn_d;
      oerr_q  <= oerr_d;
      ocor_q  <= ocor_d;
      opos_q  <= opos_d;
    end
  end

`ifdef CRC_CORRECT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cand_q <= 4'b0001;
    else          cand_q <= cand_d;
  end
`endif

  assign bus.in_ready      = (state_q == IDLE);
  assign bus.out_valid     = (state_q == DONE);
  assign bus.out_data      = odat_q;
  assign bus.out_syndrome  = osyn_q;
  assign bus.out_err       = oerr_q;
  assign bus.out_corrected = ocor_q;
  assign bus.out_err_pos   = opos_q;

endmodule

// File: tb/tb_crc_frame_checker.sv
// Directed bench for crc_frame_checker, valid with or without
// CRC_CORRECT_EN.
module tb_crc_frame_checker;

`ifdef CRC_CORRECT_EN
  localparam bit COR = 1'b1;
`else
  localparam bit COR = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  crc_frame_checker_if bus ();

  crc_frame_checker dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [14:0] code,
                      output int lat);
    @(negedge clk);
    chk("acc_rdy", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_code  = code;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic frame(input string tag,
                       input logic [14:0] code,
                       input logic [10:0] dat_c,
                       input logic [3:0]  syn,
                       input logic [3:0]  pos_c,
                       input int          lat_c);
    int   lat;
    logic ce;
    send(code, lat);
    ce = COR && (syn != 4'd0);
    chk({tag, "_lat"}, 32'(lat), ce ? 32'(lat_c) : 32'd16);
    chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_dat"}, 32'(bus.out_data),
        ce ? 32'(dat_c) : 32'(code[14:4]));
    chk({tag, "_syn"}, 32'(bus.out_syndrome), 32'(syn));
    chk({tag, "_err"}, 32'(bus.out_err), 32'(syn != 4'd0));
    chk({tag, "_cor"}, 32'(bus.out_corrected), 32'(ce));
    chk({tag, "_pos"}, 32'(bus.out_err_pos),
        ce ? 32'(pos_c) : 32'hF);
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_rel_vld"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_rel_rdy"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [10:0] hd;
    logic [3:0]  hp;
    n_cmp = 0;
    n_bad = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 32'(bus.out_valid), 32'd0);
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);
    chk("rst_dat", 32'(bus.out_data), 32'd0);
    chk("rst_syn", 32'(bus.out_syndrome), 32'd0);
    chk("rst_err", 32'(bus.out_err), 32'd0);
    chk("rst_cor", 32'(bus.out_corrected), 32'd0);
    chk("rst_pos", 32'(bus.out_err_pos), 32'hF);
    @(negedge clk);
    reset_n = 1'b1;

    frame("clean", 15'h0013, 11'h001, 4'h0, 4'hF, 16);
    release_out("clean");
    frame("b14", 15'h4013, 11'h001, 4'h9, 4'd14, 31);
    release_out("b14");
    frame("b2", 15'h0017, 11'h001, 4'h4, 4'd2, 19);
    release_out("b2");
    frame("b0", 15'h0012, 11'h001, 4'h1, 4'd0, 17);
    release_out("b0");
    frame("dbl", 15'h0010, 11'h000, 4'h3, 4'd4, 21);

    hd = bus.out_data;
    hp = bus.out_err_pos;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_code  = 15'h4013;
      @(posedge clk);
      #1;
      chk("bp_vld", 32'(bus.out_valid), 32'd1);
      chk("bp_rdy", 32'(bus.in_ready), 32'd0);
      chk("bp_dat", 32'(bus.out_data), COR ? 32'h000 : 32'h001);
      chk("bp_pos", 32'(bus.out_err_pos), COR ? 32'd4 : 32'hF);
      chk("bp_hold", 32'({bus.out_data, bus.out_err_pos}),
          32'({hd, hp}));
    end
    bus.in_valid = 1'b0;
    release_out("dbl");
    @(posedge clk);
    #1;
    chk("idle_vld", 32'(bus.out_valid), 32'd0);
    chk("idle_rdy", 32'(bus.in_ready), 32'd1);

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_code  = 15'h4013;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("mid_rdy", 32'(bus.in_ready), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mrst_vld", 32'(bus.out_valid), 32'd0);
    chk("mrst_rdy", 32'(bus.in_ready), 32'd1);
    chk("mrst_pos", 32'(bus.out_err_pos), 32'hF);
    chk("mrst_cor", 32'(bus.out_corrected), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    frame("post", 15'h0013, 11'h001, 4'h0, 4'hF, 16);
    release_out("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/crc_frame_checker.md
# crc_frame_checker

- Receive-side stage that consumes 15-bit codewords produced by the serial CRC-4 encoder: 11 data bits plus 4 CRC bits, generator g(x)=x^4+x+1.
- Recomputes the remainder bit-serially and flags any nonzero syndrome.
- When correction is compiled in, finds the single errored bit position by sequential search and flips it before releasing the 11 data bits downstream.

## Interface
Parameters:
- none; widths (CODE_W=15, DATA_W=11, CRC_W=4) are fixed constants in crc_pkg.

Ports:
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_code is valid
- in_ready  out  1  high only in IDLE
- in_code  in  15  received codeword; [14:4] data, [3:0] CRC; bit k is the coefficient of x^k
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream accepts
- out_data  out  11  data bits [14:4], corrected when applicable
- out_syndrome  out  4  remainder {x^3..x^0}
- out_err  out  1  syndrome nonzero
- out_corrected  out  1  a bit flip was applied
- out_err_pos  out  4  errored bit index 0..14; 4'hF when none

## Operation
FSM states:
- IDLE: in_ready=1. On in_valid, latch in_code into the codeword register, clear the LFSR and bit counter, go to CALC.
- CALC: feed one bit per cycle, MSB first (bit 14 first), for 15 cycles.
  - LFSR step: D<=C, C<=B, B<=A^D, A<=bit^D. Syndrome is {D,C,B,A}.
  - After the 15th bit: if the syndrome is 0, go to DONE. Otherwise go to LOCATE.
  - Without the macro, always go to DONE.
- LOCATE: candidate cand starts at 4'b0001 (x^0), index j starts at 0.
  - Each cycle: if cand==syndrome, flip codeword bit j, set out_err_pos=j, set out_corrected=1, go to DONE.
  - Otherwise cand<=cand·x mod g (same step with bit=0), j<=j+1.
  - Guard: if j reaches 15 without a match, go to DONE with out_corrected=0.
- DONE: out_valid=1, all outputs stable. On out_ready, go to IDLE.

Rules:
- out_err = |syndrome.
- An error in bits 3..0 is still corrected and reported, but out_data is unchanged.
- Double errors are miscorrected by construction. This is an accepted limitation and no detection is required.
- Reset (including mid-CALC or mid-LOCATE) discards the frame and returns to IDLE.
- Reset values: out_valid=0, out_data=0, out_syndrome=0, out_err=0, out_corrected=0, out_err_pos=4'hF, in_ready=1.

## Timing
- Accept at cycle T (in_valid&&in_ready). CALC runs cycles T+1..T+15.
- Syndrome 0: out_valid from T+16.
- Error at bit k: LOCATE runs T+16..T+16+k, out_valid from T+17+k. Worst case T+31.
- Handshake: out_valid&&out_ready at cycle U gives out_valid=0 and in_ready=1 at U+1. There is no same-cycle bypass.
- in_ready is 0 from T+1 until the return to IDLE. in_valid during that window is ignored.
- Outputs change only on entry to DONE or on reset.

## Configuration
- Macro: CRC_CORRECT_EN.
- Defined: LOCATE state and bit flip are present, behaving as above.
- Undefined:
  - Detect-only; CALC always goes to DONE.
  - out_corrected=0, out_err_pos=4'hF, out_data=in_code[14:4] raw.
  - Latency is fixed at T+16.

## Structure
- crc_pkg holds:
  - CODE_W, DATA_W, CRC_W, POLY=4'b0011 (x^4 ≡ x+1).
  - FSM state enum {IDLE, CALC, LOCATE, DONE}.
  - NO_POS=4'hF.
- One sub-module, crc_lfsr4: a combinational step, next={C, B, A^D, bit^D}. It is instanced once and shared by CALC (bit=serial input) and LOCATE (bit=0, state=cand).

## Test plan
- Clean codeword 15'h0013 (data 11'h001) accepted at T → out_valid at T+16, out_data=11'h001, syndrome 0, out_err=0, out_err_pos=4'hF.
- Bit 14 flipped, 15'h4013 → syndrome 4'b1001, out_err_pos=14, out_corrected=1, out_data=11'h001, out_valid at T+31.
  - Without macro: out_data=11'h401, out_corrected=0, out_valid at T+16.
- Bit 2 flipped, 15'h0017 → syndrome 4'b0100, out_err_pos=2, out_data=11'h001, out_valid at T+19.
- Double error, 15'h0010 → syndrome 4'b0011, out_err_pos=4, out_data=11'h000, out_corrected=1 (documented miscorrection).
- Backpressure: out_ready low for 5 cycles in DONE → outputs stable, in_ready=0, in_valid pulses ignored. Accept at U → in_ready=1 at U+1.
- reset_n low at T+7 → immediately out_valid=0, out_err_pos=4'hF, in_ready=1. The next frame 15'h0013 then completes normally at its own T+16.
